// File: rtl/ibex_multdiv_pkg.sv
// Shared types and constants for the multiply/divide issue stage.
// Optional feature macro: MULTDIV_DIV0_FASTPATH_EN (see ibex_multdiv_issue).
package ibex_multdiv_pkg;

    // Operator encoding on the request and multiplier/divider sides.
    typedef enum logic [1:0] {
        MD_OP_MULL = 2'd0,
        MD_OP_MULH = 2'd1,
        MD_OP_DIV  = 2'd2,
        MD_OP_REM  = 2'd3
    } md_op_e;

    // Issue FSM states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_RESP  = 2'd2,
        ST_ABORT = 2'd3
    } md_state_e;

    // Width of the WAIT-cycle watchdog counter (holds MAX_LAT up to 63).
    localparam int unsigned MD_CNT_W = 6;

    // Architectural quotient for a division by zero.
    localparam logic [31:0] MD_DIV0_QUOT = 32'hFFFF_FFFF;

    // True for operators that go to the divider.
    function automatic logic md_is_div(input md_op_e op);
        return (op == MD_OP_DIV) || (op == MD_OP_REM);
    endfunction

endpackage

// File: rtl/ibex_multdiv_wdog.sv
// Watchdog for the WAIT state: counts WAIT cycles and flags the last one.
// hit_o is high during the MAX_LAT-th consecutive enabled cycle, so the
// issue FSM spends exactly MAX_LAT cycles in WAIT before timing out.
module ibex_multdiv_wdog
    import ibex_multdiv_pkg::*;
#(
    parameter int unsigned MAX_LAT = 40
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clr_i,
    input  logic en_i,
    output logic hit_o
);

    localparam logic [MD_CNT_W-1:0] LAST_CNT = MD_CNT_W'(MAX_LAT - 1);

    logic [MD_CNT_W-1:0] cnt_q;
    logic [MD_CNT_W-1:0] cnt_d;

    assign hit_o = en_i && (cnt_q == LAST_CNT);

    // Clear has priority; the count saturates at the match value.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (en_i && !hit_o) begin
            cnt_d = cnt_q + MD_CNT_W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/ibex_multdiv_issue.sv
// Issue stage between the decoder and a slow multiplier/divider.
// Accepts one request, holds the enables to the multiplier/divider while
// waiting for md_valid_i, returns a tagged response, and supports flush,
// a latency watchdog and asynchronous reset.
// Optional macro MULTDIV_DIV0_FASTPATH_EN: DIV/REM by zero answers
// directly without launching the divider.
//
// Handshakes: a request transfers when req_valid_i && req_ready_o at a
// rising edge; a response transfers when rsp_valid_o && rsp_ready_i.
// rsp_valid_o, once high, stays high with stable payload until accepted
// or flushed.
module ibex_multdiv_issue
    import ibex_multdiv_pkg::*;
#(
    parameter int unsigned MAX_LAT = 40
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic [1:0]  req_operator_i,
    input  logic [1:0]  req_signed_mode_i,
    input  logic [31:0] req_op_a_i,
    input  logic [31:0] req_op_b_i,
    input  logic [4:0]  req_tag_i,
    input  logic        flush_i,
    output logic        md_mult_en_o,
    output logic        md_div_en_o,
    output logic [1:0]  md_operator_o,
    output logic [1:0]  md_signed_mode_o,
    output logic [31:0] md_op_a_o,
    output logic [31:0] md_op_b_o,
    input  logic        md_valid_i,
    input  logic [31:0] md_result_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_result_o,
    output logic [4:0]  rsp_tag_o,
    output logic        rsp_err_o,
    output logic        busy_o,
    output logic [1:0]  dbg_state_o
);

    md_state_e   state_q, state_d;
    md_op_e      op_q, op_d;
    logic [1:0]  sgn_q, sgn_d;
    logic [31:0] op_a_q, op_a_d;
    logic [31:0] op_b_q, op_b_d;
    logic [4:0]  tag_q, tag_d;
    logic [31:0] result_q, result_d;
    logic        err_q, err_d;

    logic        in_wait;
    logic        req_hs;
    logic        wdog_hit;

    assign in_wait     = (state_q == ST_WAIT);
    assign req_ready_o = !flush_i &&
                         ((state_q == ST_IDLE) || ((state_q == ST_RESP) && rsp_ready_i));
    assign req_hs      = req_valid_i && req_ready_o;

    // The counter is held clear outside WAIT, so every WAIT entry starts at 0.
    ibex_multdiv_wdog #(
        .MAX_LAT (MAX_LAT)
    ) u_wdog (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .clr_i  (!in_wait),
        .en_i   (in_wait),
        .hit_o  (wdog_hit)
    );

    // Next-state logic; a request handshake overrides the RESP exit so a new
    // operation can follow the accepted response with no bubble.
    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        sgn_d    = sgn_q;
        op_a_d   = op_a_q;
        op_b_d   = op_b_q;
        tag_d    = tag_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_IDLE;
            end
            ST_WAIT: begin
                // Flush beats a completing result and the watchdog.
                if (flush_i) begin
                    state_d = ST_ABORT;
                end else if (md_valid_i) begin
                    state_d  = ST_RESP;
                    result_d = md_result_i;
                    err_d    = 1'b0;
                end else if (wdog_hit) begin
                    state_d  = ST_RESP;
                    result_d = '0;
                    err_d    = 1'b1;
                end
            end
            ST_RESP: begin
                if (flush_i || rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (req_hs) begin
            state_d = ST_WAIT;
            op_d    = md_op_e'(req_operator_i);
            sgn_d   = req_signed_mode_i;
            op_a_d  = req_op_a_i;
            op_b_d  = req_op_b_i;
            tag_d   = req_tag_i;
            err_d   = 1'b0;
`ifdef MULTDIV_DIV0_FASTPATH_EN
            // Division by zero has a fixed architectural answer; skip the divider.
            if (md_is_div(md_op_e'(req_operator_i)) && (req_op_b_i == 32'd0)) begin
                state_d  = ST_RESP;
                result_d = (md_op_e'(req_operator_i) == MD_OP_REM) ? req_op_a_i : MD_DIV0_QUOT;
            end
`endif
        end
    end

    // State and payload registers; reset drops any in-flight operation.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            op_q     <= MD_OP_MULL;
            sgn_q    <= '0;
            op_a_q   <= '0;
            op_b_q   <= '0;
            tag_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            sgn_q    <= sgn_d;
            op_a_q   <= op_a_d;
            op_b_q   <= op_b_d;
            tag_q    <= tag_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign md_mult_en_o     = in_wait && !md_is_div(op_q);
    assign md_div_en_o      = in_wait && md_is_div(op_q);
    assign md_operator_o    = op_q;
    assign md_signed_mode_o = sgn_q;
    assign md_op_a_o        = op_a_q;
    assign md_op_b_o        = op_b_q;

    assign rsp_valid_o  = (state_q == ST_RESP);
    assign rsp_result_o = result_q;
    assign rsp_tag_o    = tag_q;
    assign rsp_err_o    = err_q;
    assign busy_o       = in_wait || (state_q == ST_ABORT);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_ibex_multdiv_issue.sv
// Directed bench for ibex_multdiv_issue with MAX_LAT = 4. Inputs change and
// outputs are sampled on the falling clock edge; the bench plays the role of
// the multiplier/divider by pulsing md_valid_i on a chosen WAIT cycle.
module tb_ibex_multdiv_issue;
    import ibex_multdiv_pkg::*;

    localparam int unsigned MAX_LAT = 4;
    localparam int          TIMEOUT = 20;

    // Clock / reset
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // DUT signals
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [1:0]  req_operator = 2'd0;
    logic [1:0]  req_signed = 2'd0;
    logic [31:0] req_a = '0;
    logic [31:0] req_b = '0;
    logic [4:0]  req_tag = '0;
    logic        flush = 1'b0;
    logic        mult_en;
    logic        div_en;
    logic [1:0]  md_operator;
    logic [1:0]  md_signed;
    logic [31:0] md_a;
    logic [31:0] md_b;
    logic        md_valid = 1'b0;
    logic [31:0] md_result = '0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_result;
    logic [4:0]  rsp_tag;
    logic        rsp_err;
    logic        busy;
    logic [1:0]  dbg_state;

    ibex_multdiv_issue #(
        .MAX_LAT (MAX_LAT)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .req_valid_i       (req_valid),
        .req_ready_o       (req_ready),
        .req_operator_i    (req_operator),
        .req_signed_mode_i (req_signed),
        .req_op_a_i        (req_a),
        .req_op_b_i        (req_b),
        .req_tag_i         (req_tag),
        .flush_i           (flush),
        .md_mult_en_o      (mult_en),
        .md_div_en_o       (div_en),
        .md_operator_o     (md_operator),
        .md_signed_mode_o  (md_signed),
        .md_op_a_o         (md_a),
        .md_op_b_o         (md_b),
        .md_valid_i        (md_valid),
        .md_result_i       (md_result),
        .rsp_valid_o       (rsp_valid),
        .rsp_ready_i       (rsp_ready),
        .rsp_result_o      (rsp_result),
        .rsp_tag_o         (rsp_tag),
        .rsp_err_o         (rsp_err),
        .busy_o            (busy),
        .dbg_state_o       (dbg_state)
    );

    // Scoreboard
    int n_tests = 0;
    int n_fail  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [1:0]  op;
        logic [1:0]  sgn;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  tag;
        int          md_cyc;    // WAIT cycle index carrying md_valid_i
        logic [31:0] md_res;
        logic [31:0] exp_res;
        logic        exp_err;
        int          exp_wait;  // cycles between handshake and RESP
        int          exp_mult;  // cycles with md_mult_en_o high
        int          exp_div;   // cycles with md_div_en_o high
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    // Driver tasks
    task automatic drive_req(input logic [1:0] op, input logic [1:0] sgn,
                             input logic [31:0] a, input logic [31:0] b,
                             input logic [4:0] tag);
        req_valid    = 1'b1;
        req_operator = op;
        req_signed   = sgn;
        req_a        = a;
        req_b        = b;
        req_tag      = tag;
    endtask

    // Issues one vector from IDLE, plays the multiplier/divider, then accepts the response.
    task automatic run_vec(input vec_t v, input int idx);
        int cyc;
        int n_mult;
        int n_div;
        logic [31:0] exp_res;
        n_mult = 0;
        n_div  = 0;
        drive_req(v.op, v.sgn, v.a, v.b, v.tag);
        exp_q.push_back(v.exp_res);
        #1 check($sformatf("v%0d_req_ready", idx), 32'(req_ready), 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        cyc = 0;
        while (!rsp_valid && cyc < TIMEOUT) begin
            if (cyc == 0) begin
                check($sformatf("v%0d_md_op_a", idx), md_a, v.a);
                check($sformatf("v%0d_md_op_b", idx), md_b, v.b);
                check($sformatf("v%0d_md_ctrl", idx), {28'd0, md_operator, md_signed}, {28'd0, v.op, v.sgn});
            end
            n_mult += int'(mult_en);
            n_div  += int'(div_en);
            md_valid  = (cyc == v.md_cyc);
            md_result = v.md_res;
            @(negedge clk);
            md_valid = 1'b0;
            cyc++;
        end
        check($sformatf("v%0d_rsp_valid", idx), 32'(rsp_valid), 32'd1);
        exp_res = exp_q.pop_front();
        check($sformatf("v%0d_result", idx), rsp_result, exp_res);
        check($sformatf("v%0d_tag", idx), 32'(rsp_tag), 32'(v.tag));
        check($sformatf("v%0d_err", idx), 32'(rsp_err), 32'(v.exp_err));
        check($sformatf("v%0d_latency", idx), 32'(cyc), 32'(v.exp_wait));
        check($sformatf("v%0d_mult_cycles", idx), 32'(n_mult), 32'(v.exp_mult));
        check($sformatf("v%0d_div_cycles", idx), 32'(n_div), 32'(v.exp_div));
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        check($sformatf("v%0d_rsp_gone", idx), {30'd0, rsp_valid, busy}, 32'd0);
    endtask

    // Safety net against a hung run.
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, %0d tests run", n_tests);
        $fatal(1, "timeout");
    end

    initial begin
        int seen;

        vecs[0] = '{MD_OP_MULL, 2'b00, 32'd7, 32'd6, 5'd5, 2, 32'd42, 32'd42, 1'b0, 3, 3, 0};
        vecs[1] = '{MD_OP_MULH, 2'b11, 32'h8000_0000, 32'd2, 5'd17, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1, 1, 0};
        vecs[2] = '{MD_OP_DIV, 2'b11, 32'd100, 32'd7, 5'd3, 1, 32'd14, 32'd14, 1'b0, 2, 0, 2};
        vecs[3] = '{MD_OP_REM, 2'b00, 32'd100, 32'd7, 5'd31, 3, 32'd2, 32'd2, 1'b0, 4, 0, 4};
        vecs[4] = '{MD_OP_MULL, 2'b00, 32'h1234, 32'h10, 5'd0, 99, 32'hDEAD, 32'd0, 1'b1, 4, 4, 0};
`ifdef MULTDIV_DIV0_FASTPATH_EN
        vecs[5] = '{MD_OP_DIV, 2'b11, 32'd100, 32'd0, 5'd9, 99, 32'd0, 32'hFFFF_FFFF, 1'b0, 0, 0, 0};
        vecs[6] = '{MD_OP_REM, 2'b01, 32'd55, 32'd0, 5'd12, 99, 32'd0, 32'd55, 1'b0, 0, 0, 0};
`else
        vecs[5] = '{MD_OP_DIV, 2'b11, 32'd100, 32'd0, 5'd9, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 2, 0, 2};
        vecs[6] = '{MD_OP_REM, 2'b01, 32'd55, 32'd0, 5'd12, 0, 32'd55, 32'd55, 1'b0, 1, 0, 1};
`endif

        // Reset state
        #2;
        check("reset_req_ready", 32'(req_ready), 32'd1);
        check("reset_flags", {26'd0, rsp_valid, busy, mult_en, div_en, rsp_err, 1'b0}, 32'd0);
        check("reset_result", rsp_result, 32'd0);
        check("reset_md_ops", md_a | md_b, 32'd0);
        check("reset_state", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Table-driven vectors
        for (int i = 0; i < 7; i++) begin
            run_vec(vecs[i], i);
        end

        // Flush in the 2nd WAIT cycle together with md_valid_i
        drive_req(MD_OP_MULL, 2'b00, 32'd3, 32'd4, 5'd1);
        @(negedge clk);
        req_valid = 1'b0;
        check("flush_wait0_state", 32'(dbg_state), 32'(ST_WAIT));
        @(negedge clk);
        flush     = 1'b1;
        md_valid  = 1'b1;
        md_result = 32'd12;
        @(negedge clk);
        flush    = 1'b0;
        md_valid = 1'b0;
        check("flush_abort_state", 32'(dbg_state), 32'(ST_ABORT));
        check("flush_abort_outs", {29'd0, rsp_valid, mult_en, div_en}, 32'd0);
        check("flush_abort_busy", 32'(busy), 32'd1);
        #1 check("flush_abort_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("flush_idle_state", 32'(dbg_state), 32'(ST_IDLE));
        check("flush_idle_outs", {29'd0, rsp_valid, busy, mult_en}, 32'd0);
        #1 check("flush_idle_ready", 32'(req_ready), 32'd1);

        // Flush while a response is pending drops it and blocks a new request
        drive_req(MD_OP_MULH, 2'b00, 32'd5, 32'd5, 5'd2);
        @(negedge clk);
        req_valid = 1'b0;
        md_valid  = 1'b1;
        md_result = 32'd25;
        @(negedge clk);
        md_valid = 1'b0;
        check("rflush_rsp_valid", 32'(rsp_valid), 32'd1);
        flush     = 1'b1;
        rsp_ready = 1'b1;
        drive_req(MD_OP_MULL, 2'b00, 32'd1, 32'd1, 5'd6);
        #1 check("rflush_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        flush     = 1'b0;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("rflush_state", 32'(dbg_state), 32'(ST_IDLE));
        check("rflush_outs", {30'd0, rsp_valid, busy}, 32'd0);

        // Backpressure: payload stable, then back-to-back issue
        drive_req(MD_OP_MULL, 2'b00, 32'd2, 32'd3, 5'd7);
        @(negedge clk);
        req_valid = 1'b0;
        md_valid  = 1'b1;
        md_result = 32'd6;
        @(negedge clk);
        md_valid  = 1'b0;
        md_result = 32'h5555_5555;
        seen = 0;
        for (int c = 0; c < 5; c++) begin
            if (rsp_valid && rsp_result == 32'd6 && rsp_tag == 5'd7 && !rsp_err) seen++;
            @(negedge clk);
        end
        check("bp_stable_cycles", 32'(seen), 32'd5);
        rsp_ready = 1'b1;
        drive_req(MD_OP_DIV, 2'b00, 32'd9, 32'd3, 5'd8);
        #1 check("bp_b2b_ready", 32'(req_ready), 32'd1);
        @(negedge clk);
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        check("bp_b2b_state", 32'(dbg_state), 32'(ST_WAIT));
        check("bp_b2b_enables", {29'd0, rsp_valid, mult_en, div_en}, 32'd1);
        md_valid  = 1'b1;
        md_result = 32'd3;
        @(negedge clk);
        md_valid = 1'b0;
        check("bp_b2b_result", rsp_result, 32'd3);
        check("bp_b2b_tag", 32'(rsp_tag), 32'd8);
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;

        // Reset pulse mid-WAIT
        drive_req(MD_OP_MULL, 2'b00, 32'd1, 32'd1, 5'd4);
        @(negedge clk);
        req_valid = 1'b0;
        check("rst_wait_mult_en", 32'(mult_en), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_async_outs", {29'd0, mult_en, busy, rsp_valid}, 32'd0);
        check("rst_async_state", 32'(dbg_state), 32'(ST_IDLE));
        md_valid  = 1'b1;
        md_result = 32'd99;
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int c = 0; c < 6; c++) begin
            if (c == 3) md_valid = 1'b0;
            if (rsp_valid || mult_en || div_en) seen++;
            @(negedge clk);
        end
        check("rst_no_response", 32'(seen), 32'd0);
        check("rst_final_state", 32'(dbg_state), 32'(ST_IDLE));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
